segment_fifo_reader: RTL

//  Consumer side of the four parallel line-coordinate FIFOs (x0/y0/x1/y1) that the buffer controller fills.

---
 rtl/segment_fifo_reader.sv | 121 ++++++++++++
 1 files changed

// File: rtl/segment_fifo_reader.sv
// Flow-controlled consumer of the x0/y0/x1/y1 FIFO bank; one segment per valid/ready handoff.
// Define SEG_CLIP_EN to clamp captured coordinates to the screen.
module segment_fifo_reader #(
    parameter int COORD_W  = 11,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               empty_x0,
    input  logic               empty_y0,
    input  logic               empty_x1,
    input  logic               empty_y1,
    input  logic [COORD_W-1:0] q_x0,
    input  logic [COORD_W-1:0] q_y0,
    input  logic [COORD_W-1:0] q_x1,
    input  logic [COORD_W-1:0] q_y1,
    output logic               rd_req,
    output logic [COORD_W-1:0] x0,
    output logic [COORD_W-1:0] y0,
    output logic [COORD_W-1:0] x1,
    output logic [COORD_W-1:0] y1,
    output logic               seg_valid,
    input  logic               seg_ready,
    output logic               busy,
    output logic [CNT_W-1:0]   seg_count,
    output logic               desync_err
);

    typedef enum logic [1:0] {
        IDLE,
        POP,
        CAPTURE,
        PRESENT
    } state_t;

    state_t state;

    logic any_empty;
    logic all_empty;
    logic [COORD_W-1:0] cx0, cy0, cx1, cy1;

    assign any_empty = empty_x0 | empty_y0 | empty_x1 | empty_y1;
    assign all_empty = empty_x0 & empty_y0 & empty_x1 & empty_y1;
    assign busy      = (state != IDLE);

`ifdef SEG_CLIP_EN
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(SCREEN_H - 1);

    function automatic logic [COORD_W-1:0] clip(
        input logic [COORD_W-1:0] v,
        input logic [COORD_W-1:0] lim
    );
        return (v > lim) ? lim : v;
    endfunction

    assign cx0 = clip(q_x0, X_MAX);
    assign cy0 = clip(q_y0, Y_MAX);
    assign cx1 = clip(q_x1, X_MAX);
    assign cy1 = clip(q_y1, Y_MAX);
`else
    logic unused_screen;
    assign unused_screen = ^{SCREEN_W, SCREEN_H};

    assign cx0 = q_x0;
    assign cy0 = q_y0;
    assign cx1 = q_x1;
    assign cy1 = q_y1;
`endif

    // FIFO data is valid in the cycle after POP and is registered as that
    // cycle ends, so seg_valid rises three cycles after the deciding IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rd_req     <= 1'b0;
            seg_valid  <= 1'b0;
            x0         <= '0;
            y0         <= '0;
            x1         <= '0;
            y1         <= '0;
            seg_count  <= '0;
            desync_err <= 1'b0;
        end else begin
            rd_req <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_empty && !all_empty)
                        desync_err <= 1'b1;
                    if (enable && !any_empty) begin
                        rd_req <= 1'b1;
                        state  <= POP;
                    end
                end
                POP: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    x0        <= cx0;
                    y0        <= cy0;
                    x1        <= cx1;
                    y1        <= cy1;
                    seg_valid <= 1'b1;
                    state     <= PRESENT;
                end
                PRESENT: begin
                    if (seg_ready) begin
                        seg_valid <= 1'b0;
                        seg_count <= seg_count + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
